cc_timescheduler: RTL and testbench



---
 rtl/cc_timescheduler_pkg.sv | 21 ++
 rtl/cc_rr_arbiter.sv | 41 ++++
 rtl/cc_timescheduler.sv | 171 +++++++++++++++++
 tb/tb_cc_timescheduler.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_timescheduler_pkg.sv
// ============================================================================
// Module      : cc_timescheduler_pkg
// Description : Shared FSM encodings and constants for the FROGGER time base.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cc_timescheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } ts_state_t;

   localparam int          C_LEVEL_W        = 3;
   localparam logic [23:0] C_DEFAULT_PERIOD = 24'hFFE400;

endpackage

`default_nettype wire

// File: rtl/cc_rr_arbiter.sv
// ============================================================================
// Module      : cc_rr_arbiter
// Description : Combinational round-robin pick of the first pending lane at or
//               after the pointer, with the pointer value that follows it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cc_rr_arbiter #(
   parameter int LANES = 4,
   parameter int PTR_W = 2
) (
   input  logic [LANES-1:0] i_pending,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [LANES-1:0] o_grant,
   output logic [PTR_W-1:0] o_next_ptr,
   output logic             o_valid
);

   logic [PTR_W-1:0] w_idx;

   // Scan from the farthest candidate back to the pointer so the nearest wins.
   always_comb begin
      o_grant    = '0;
      o_next_ptr = i_ptr;
      o_valid    = 1'b0;
      w_idx      = '0;
      for (int k = LANES - 1; k >= 0; k--) begin
         w_idx = PTR_W'((int'(i_ptr) + k) % LANES);
         if (i_pending[w_idx]) begin
            o_grant        = '0;
            o_grant[w_idx] = 1'b1;
            o_next_ptr     = PTR_W'((int'(i_ptr) + k + 1) % LANES);
            o_valid        = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/cc_timescheduler.sv
// ============================================================================
// Module      : cc_timescheduler
// Description : Scheduled game time base: prescaler tick, per-lane dividers and
//               one round-robin lane step grant per clock.
//               Optional macro TIMESCHEDULER_OVERRUN_EN adds the sticky overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cc_timescheduler
   import cc_timescheduler_pkg::*;
#(
   parameter int                                 TIMESCHEDULER_DATAWIDTH = 24,
   parameter logic [TIMESCHEDULER_DATAWIDTH-1:0] TIMESCHEDULER_PERIOD    =
      TIMESCHEDULER_DATAWIDTH'(C_DEFAULT_PERIOD),
   parameter int                                 TIMESCHEDULER_LANES     = 4,
   parameter int                                 TIMESCHEDULER_DIVWIDTH  = 4
) (
   input  logic                                              CC_TIMESCHEDULER_CLOCK_50,
   input  logic                                              CC_TIMESCHEDULER_RESET_InHigh,
   input  logic                                              CC_TIMESCHEDULER_start_InLow,
   input  logic                                              CC_TIMESCHEDULER_pause_InLow,
   input  logic [C_LEVEL_W-1:0]                              CC_TIMESCHEDULER_level_InBUS,
   input  logic [TIMESCHEDULER_LANES*TIMESCHEDULER_DIVWIDTH-1:0] CC_TIMESCHEDULER_div_InBUS,
   output logic                                              CC_TIMESCHEDULER_T0_OutLow,
   output logic [TIMESCHEDULER_LANES-1:0]                    CC_TIMESCHEDULER_step_OutBUS,
`ifdef TIMESCHEDULER_OVERRUN_EN
   output logic                                              CC_TIMESCHEDULER_overrun_Out,
`endif
   output logic                                              CC_TIMESCHEDULER_running_Out
);

   localparam int c_LANES = TIMESCHEDULER_LANES;
   localparam int c_DW    = TIMESCHEDULER_DATAWIDTH;
   localparam int c_DIVW  = TIMESCHEDULER_DIVWIDTH;
   localparam int c_PTR_W = (c_LANES > 1) ? $clog2(c_LANES) : 1;
   localparam logic [c_DW-1:0]   c_ONE     = c_DW'(1);
   localparam logic [c_DIVW-1:0] c_DIV_ONE = c_DIVW'(1);

   ts_state_t              r_state;
   logic                   r_running;
   logic [c_DW-1:0]        r_presc;
   logic                   r_t0_n;
   logic [c_LANES-1:0]     r_step;
   logic [c_LANES-1:0]     r_pending;
   logic [c_PTR_W-1:0]     r_rr;

   logic [c_DW-1:0]        w_shift;
   logic [c_DW-1:0]        w_period_m1;
   logic                   w_run;
   logic                   w_tick;
   logic [c_LANES-1:0]     w_expiry;
   logic [c_LANES-1:0]     w_arb_req;
   logic [c_LANES-1:0]     w_grant;
   logic [c_PTR_W-1:0]     w_next_ptr;
   logic                   w_grant_valid;
   logic [c_LANES-1:0]     w_pending_next;

   // A period that shifts to zero is clamped to one clock.
   assign w_shift     = TIMESCHEDULER_PERIOD >> CC_TIMESCHEDULER_level_InBUS;
   assign w_period_m1 = (w_shift == '0) ? '0 : (w_shift - c_ONE);
   assign w_run       = (r_state == ST_RUN);
   assign w_tick      = w_run && (r_presc >= w_period_m1);

   generate
      for (genvar gi = 0; gi < c_LANES; gi++) begin : g_lane
         logic [c_DIVW-1:0] w_div;
         logic [c_DIVW-1:0] r_cnt;
         logic              w_hit;

         assign w_div        = CC_TIMESCHEDULER_div_InBUS[gi*c_DIVW +: c_DIVW];
         assign w_hit        = (w_div != '0) && (r_cnt >= (w_div - c_DIV_ONE));
         assign w_expiry[gi] = w_tick && w_hit;

         always_ff @(posedge CC_TIMESCHEDULER_CLOCK_50) begin
            if (CC_TIMESCHEDULER_RESET_InHigh || (w_div == '0)) begin
               r_cnt <= '0;
            end else if (w_tick) begin
               r_cnt <= w_hit ? '0 : (r_cnt + c_DIV_ONE);
            end
         end
      end
   endgenerate

   assign w_arb_req = w_run ? r_pending : '0;

   cc_rr_arbiter #(
      .LANES (c_LANES),
      .PTR_W (c_PTR_W)
   ) u_arb (
      .i_pending  (w_arb_req),
      .i_ptr      (r_rr),
      .o_grant    (w_grant),
      .o_next_ptr (w_next_ptr),
      .o_valid    (w_grant_valid)
   );

   // A new expiry on a bit being granted this cycle re-arms it.
   assign w_pending_next = (r_pending & ~w_grant) | w_expiry;

`ifdef TIMESCHEDULER_OVERRUN_EN
   logic r_overrun;
   logic w_merge;

   assign w_merge = |(w_expiry & r_pending & ~w_grant);
   assign CC_TIMESCHEDULER_overrun_Out = r_overrun;

   always_ff @(posedge CC_TIMESCHEDULER_CLOCK_50) begin
      if (CC_TIMESCHEDULER_RESET_InHigh) begin
         r_overrun <= 1'b0;
      end else if ((r_state == ST_IDLE) && !CC_TIMESCHEDULER_start_InLow) begin
         r_overrun <= 1'b0;
      end else if (w_merge) begin
         r_overrun <= 1'b1;
      end
   end
`endif

   always_ff @(posedge CC_TIMESCHEDULER_CLOCK_50) begin
      if (CC_TIMESCHEDULER_RESET_InHigh) begin
         r_state   <= ST_IDLE;
         r_running <= 1'b0;
         r_presc   <= '0;
         r_t0_n    <= 1'b1;
         r_step    <= '0;
         r_pending <= '0;
         r_rr      <= '0;
      end else begin
         r_t0_n <= ~w_tick;
         r_step <= w_grant;
         case (r_state)
            ST_IDLE: begin
               r_presc   <= '0;
               r_pending <= '0;
               if (!CC_TIMESCHEDULER_start_InLow) begin
                  r_state   <= ST_RUN;
                  r_running <= 1'b1;
               end
            end
            ST_RUN: begin
               r_presc   <= w_tick ? '0 : (r_presc + c_ONE);
               r_pending <= w_pending_next;
               if (w_grant_valid) begin
                  r_rr <= w_next_ptr;
               end
               if (!CC_TIMESCHEDULER_pause_InLow) begin
                  r_state   <= ST_PAUSE;
                  r_running <= 1'b0;
               end
            end
            ST_PAUSE: begin
               if (CC_TIMESCHEDULER_pause_InLow && !CC_TIMESCHEDULER_start_InLow) begin
                  r_state   <= ST_RUN;
                  r_running <= 1'b1;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_running <= 1'b0;
            end
         endcase
      end
   end

   assign CC_TIMESCHEDULER_T0_OutLow   = r_t0_n;
   assign CC_TIMESCHEDULER_step_OutBUS = r_step;
   assign CC_TIMESCHEDULER_running_Out = r_running;

endmodule

`default_nettype wire

// File: tb/tb_cc_timescheduler.sv
// ============================================================================
// Module      : tb_cc_timescheduler
// Description : Self-checking bench for cc_timescheduler (PERIOD=16 and PERIOD=1 builds).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cc_timescheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_n, pause_n, start1_n;
   logic [2:0]  level;
   logic [15:0] div;
   logic        t0_n, running, t0b, runb;
   logic [3:0]  step, stepb;
`ifdef TIMESCHEDULER_OVERRUN_EN
   logic        ov, ovb;
`endif

   int          checks   = 0;
   int          failures = 0;
   logic [3:0]  exp_q[$];
   int          cyc_q[$];

   always #5 clk = ~clk;

   cc_timescheduler #(
      .TIMESCHEDULER_DATAWIDTH (24),
      .TIMESCHEDULER_PERIOD    (24'd16),
      .TIMESCHEDULER_LANES     (4),
      .TIMESCHEDULER_DIVWIDTH  (4)
   ) dut (
      .CC_TIMESCHEDULER_CLOCK_50     (clk),
      .CC_TIMESCHEDULER_RESET_InHigh (rst),
      .CC_TIMESCHEDULER_start_InLow  (start_n),
      .CC_TIMESCHEDULER_pause_InLow  (pause_n),
      .CC_TIMESCHEDULER_level_InBUS  (level),
      .CC_TIMESCHEDULER_div_InBUS    (div),
      .CC_TIMESCHEDULER_T0_OutLow    (t0_n),
      .CC_TIMESCHEDULER_step_OutBUS  (step),
`ifdef TIMESCHEDULER_OVERRUN_EN
      .CC_TIMESCHEDULER_overrun_Out  (ov),
`endif
      .CC_TIMESCHEDULER_running_Out  (running)
   );

   cc_timescheduler #(
      .TIMESCHEDULER_DATAWIDTH (24),
      .TIMESCHEDULER_PERIOD    (24'd1),
      .TIMESCHEDULER_LANES     (4),
      .TIMESCHEDULER_DIVWIDTH  (4)
   ) dut1 (
      .CC_TIMESCHEDULER_CLOCK_50     (clk),
      .CC_TIMESCHEDULER_RESET_InHigh (rst),
      .CC_TIMESCHEDULER_start_InLow  (start1_n),
      .CC_TIMESCHEDULER_pause_InLow  (1'b1),
      .CC_TIMESCHEDULER_level_InBUS  (3'd0),
      .CC_TIMESCHEDULER_div_InBUS    (16'h1111),
      .CC_TIMESCHEDULER_T0_OutLow    (t0b),
      .CC_TIMESCHEDULER_step_OutBUS  (stepb),
`ifdef TIMESCHEDULER_OVERRUN_EN
      .CC_TIMESCHEDULER_overrun_Out  (ovb),
`endif
      .CC_TIMESCHEDULER_running_Out  (runb)
   );

   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; start_n = 1'b1; pause_n = 1'b1; start1_n = 1'b1; level = 3'd0;
      step_clk();
      step_clk();
      rst = 1'b0;
      step_clk();
   endtask

   // Returns just after the edge that moves the DUT into RUN.
   task automatic start_pulse();
      start_n = 1'b0;
      step_clk();
      start_n = 1'b1;
   endtask

   task automatic test_reset();
      div = 16'h0;
      do_reset();
      rst = 1'b1;
      step_clk();
      checks++; if (t0_n !== 1'b1) begin failures++; $display("FAIL reset_t0: got %b expected 1", t0_n); end
      checks++; if (step !== 4'b0) begin failures++; $display("FAIL reset_step: got %b expected 0000", step); end
      checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running: got %b expected 0", running); end
      checks++; if (stepb !== 4'b0 || runb !== 1'b0 || t0b !== 1'b1) begin
         failures++; $display("FAIL reset_dut1: got step=%b run=%b t0=%b expected 0000 0 1", stepb, runb, t0b);
      end
`ifdef TIMESCHEDULER_OVERRUN_EN
      checks++; if (ov !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b expected 0", ov); end
`endif
      rst = 1'b0;
   endtask

   task automatic test_period();
      int got;
      do_reset();
      div = 16'h0;
      start_pulse();
      checks++; if (running !== 1'b1) begin failures++; $display("FAIL period_running: got %b expected 1", running); end
      cyc_q.push_back(16); cyc_q.push_back(32); cyc_q.push_back(48);
      for (int c = 1; c <= 55 && cyc_q.size() > 0; c++) begin
         step_clk();
         if (t0_n === 1'b0) begin
            got = cyc_q.pop_front();
            checks++; if (c != got) begin failures++; $display("FAIL period_tick: got cycle %0d expected %0d", c, got); end
         end
      end
      checks++; if (cyc_q.size() != 0) begin failures++; $display("FAIL period_timeout: got %0d ticks missing expected 0", cyc_q.size()); end
      cyc_q.delete();
   endtask

   task automatic test_level();
      int got;
      do_reset();
      div = 16'h0;
      start_pulse();
      cyc_q.push_back(11); cyc_q.push_back(15); cyc_q.push_back(19);
      for (int c = 1; c <= 25 && cyc_q.size() > 0; c++) begin
         step_clk();
         if (t0_n === 1'b0) begin
            got = cyc_q.pop_front();
            checks++; if (c != got) begin failures++; $display("FAIL level_tick: got cycle %0d expected %0d", c, got); end
         end
         if (c == 10) level = 3'd2;
      end
      checks++; if (cyc_q.size() != 0) begin failures++; $display("FAIL level_timeout: got %0d ticks missing expected 0", cyc_q.size()); end
      cyc_q.delete();
      level = 3'd0;
   endtask

   task automatic test_round_robin();
      logic [3:0] e;
      int first, last;
      do_reset();
      div = 16'h1111;
      first = -1; last = -1;
      start_pulse();
      exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
      exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
      for (int c = 1; c <= 30 && exp_q.size() > 0; c++) begin
         step_clk();
         if (step !== 4'b0) begin
            e = exp_q.pop_front();
            checks++; if (step !== e) begin failures++; $display("FAIL rr_step: got %b expected %b", step, e); end
            if (first < 0) first = c;
            last = c;
         end
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rr_timeout: got %0d steps missing expected 0", exp_q.size()); end
      checks++; if (first != 17) begin failures++; $display("FAIL rr_latency: got cycle %0d expected 17", first); end
      checks++; if (last != 20) begin failures++; $display("FAIL rr_back_to_back: got last cycle %0d expected 20", last); end
      exp_q.delete();
   endtask

   task automatic test_pause();
      logic [3:0] e;
      logic ok;
      int c;
      do_reset();
      div = 16'h1111;
      start_pulse();
      exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
      c = 0;
      while (step === 4'b0 && c < 30) begin step_clk(); c++; end
      e = exp_q.pop_front();
      checks++; if (step !== e) begin failures++; $display("FAIL pause_first: got %b expected %b", step, e); end
      pause_n = 1'b0;
      step_clk();
      pause_n = 1'b1;
      e = exp_q.pop_front();
      checks++; if (step !== e || running !== 1'b0) begin
         failures++; $display("FAIL pause_enter: got step=%b run=%b expected %b 0", step, running, e);
      end
      ok = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step_clk();
         if (step !== 4'b0 || t0_n !== 1'b1 || running !== 1'b0) ok = 1'b0;
      end
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL pause_hold: got activity=1 expected 0"); end
      exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
      start_pulse();
      checks++; if (running !== 1'b1 || step !== 4'b0) begin
         failures++; $display("FAIL pause_resume: got run=%b step=%b expected 1 0000", running, step);
      end
      for (int k = 0; k < 2; k++) begin
         step_clk();
         e = exp_q.pop_front();
         checks++; if (step !== e) begin failures++; $display("FAIL pause_resume_step: got %b expected %b", step, e); end
      end
   endtask

   task automatic test_lane_off_and_reset();
      logic [3:0] e;
      logic saw2, ok;
      int c;
      do_reset();
      div = 16'h1011;
      saw2 = 1'b0;
      start_pulse();
      for (int r = 0; r < 2; r++) begin
         exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b1000);
      end
      for (int k = 1; k <= 45 && exp_q.size() > 0; k++) begin
         step_clk();
         if (step[2] === 1'b1) saw2 = 1'b1;
         if (step !== 4'b0) begin
            e = exp_q.pop_front();
            checks++; if (step !== e) begin failures++; $display("FAIL laneoff_step: got %b expected %b", step, e); end
         end
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL laneoff_timeout: got %0d steps missing expected 0", exp_q.size()); end
      checks++; if (saw2 !== 1'b0) begin failures++; $display("FAIL laneoff_lane2: got granted expected never"); end
      exp_q.delete();

      do_reset();
      div = 16'h1111;
      start_pulse();
      c = 0;
      while (t0_n === 1'b1 && c < 30) begin step_clk(); c++; end
      checks++; if (t0_n !== 1'b0) begin failures++; $display("FAIL midreset_tick: got %b expected 0", t0_n); end
      rst = 1'b1;
      step_clk();
      checks++; if (step !== 4'b0 || t0_n !== 1'b1 || running !== 1'b0) begin
         failures++; $display("FAIL midreset_outputs: got step=%b t0=%b run=%b expected 0000 1 0", step, t0_n, running);
      end
      rst = 1'b0;
      ok = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step_clk();
         if (step !== 4'b0 || running !== 1'b0) ok = 1'b0;
      end
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL midreset_dropped: got steps after reset expected none"); end
   endtask

   task automatic test_overrun();
      logic [3:0] e;
      do_reset();
      start1_n = 1'b0;
      step_clk();
      start1_n = 1'b1;
      checks++; if (runb !== 1'b1) begin failures++; $display("FAIL ovr_running: got %b expected 1", runb); end
      for (int r = 0; r < 2; r++) begin
         exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
         exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
      end
      for (int c = 1; c <= 12; c++) begin
         step_clk();
         if (c == 1) begin
            checks++; if (t0b !== 1'b0 || stepb !== 4'b0) begin
               failures++; $display("FAIL ovr_first: got t0=%b step=%b expected 0 0000", t0b, stepb);
            end
`ifdef TIMESCHEDULER_OVERRUN_EN
            checks++; if (ovb !== 1'b0) begin failures++; $display("FAIL ovr_early: got %b expected 0", ovb); end
`endif
         end
         if (c >= 2 && c <= 9) begin
            e = exp_q.pop_front();
            checks++; if (stepb !== e) begin failures++; $display("FAIL ovr_step: got %b expected %b", stepb, e); end
`ifdef TIMESCHEDULER_OVERRUN_EN
            checks++; if (ovb !== 1'b1) begin failures++; $display("FAIL ovr_sticky: got %b expected 1", ovb); end
`endif
         end
      end
      rst = 1'b1;
      step_clk();
      rst = 1'b0;
      checks++; if (runb !== 1'b0 || stepb !== 4'b0) begin
         failures++; $display("FAIL ovr_reset: got run=%b step=%b expected 0 0000", runb, stepb);
      end
`ifdef TIMESCHEDULER_OVERRUN_EN
      checks++; if (ovb !== 1'b0) begin failures++; $display("FAIL ovr_clear: got %b expected 0", ovb); end
`endif
      exp_q.delete();
   endtask

   initial begin
      rst = 1'b1; start_n = 1'b1; pause_n = 1'b1; start1_n = 1'b1;
      level = 3'd0; div = 16'h0;
      test_reset();
      test_period();
      test_level();
      test_round_robin();
      test_pause();
      test_lane_off_and_reset();
      test_overrun();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
